// File: rtl/rle_zrl_suppress.sv
// rle_zrl_suppress: holds up to DEPTH ZRL tokens, dropping them at EOB and replaying them ahead of the next DATA token
module rle_zrl_suppress #(
  parameter int SIZE_W      = 4,
  parameter int AMP_W       = 12,
  parameter int DEPTH       = 3,
  parameter int CNT_W       = 16,
  parameter int SUPPRESS_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_run,
  input  logic [SIZE_W-1:0] in_size,
  input  logic [AMP_W-1:0]  in_amp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_run,
  output logic [SIZE_W-1:0] out_size,
  output logic [AMP_W-1:0]  out_amp,
  output logic [CNT_W-1:0]  zrl_dropped
);
  localparam int ZW = $clog2(DEPTH + 1);
  localparam logic S_IDLE  = 1'b0;
  localparam logic S_FLUSH = 1'b1;
  localparam logic [ZW-1:0] ZMAX = ZW'(DEPTH);
  logic              r_state, r_valid;
  logic [3:0]        r_run, r_h_run;
  logic [SIZE_W-1:0] r_size, r_h_size;
  logic [AMP_W-1:0]  r_amp, r_h_amp;
  logic [ZW-1:0]     r_zcnt;
  logic [CNT_W-1:0]  r_drop;
  logic              w_free, w_acc, w_zrl, w_eob, w_ld, w_hold_en, w_state_n;
  logic [3:0]        w_ld_run;
  logic [SIZE_W-1:0] w_ld_size;
  logic [AMP_W-1:0]  w_ld_amp;
  logic [ZW-1:0]     w_zcnt_n;
  logic [CNT_W-1:0]  w_drop_n;
  logic [CNT_W:0]    w_sum;
  assign w_free      = !r_valid | out_ready;
  assign in_ready    = (r_state == S_IDLE) & w_free;
  assign w_acc       = in_valid & in_ready;
  assign w_zrl       = (in_run == 4'd15) & (in_size == '0);
  assign w_eob       = (in_run == 4'd0) & (in_size == '0);
  assign w_sum       = {1'b0, r_drop} + (CNT_W+1)'(r_zcnt);
  assign out_valid   = r_valid;
  assign out_run     = r_run;
  assign out_size    = r_size;
  assign out_amp     = r_amp;
  assign zrl_dropped = r_drop;
  always_comb begin
    w_ld      = 1'b0;
    w_ld_run  = in_run;
    w_ld_size = in_size;
    w_ld_amp  = in_amp;
    w_zcnt_n  = r_zcnt;
    w_state_n = r_state;
    w_hold_en = 1'b0;
    w_drop_n  = r_drop;
    if (SUPPRESS_EN == 0) begin
      w_ld = w_acc;
    end else if (r_state == S_FLUSH) begin
      // replay remaining held ZRLs, then the parked DATA token
      w_ld = w_free;
      if (r_zcnt != '0) begin
        w_ld_run  = 4'd15;
        w_ld_size = '0;
        w_ld_amp  = '0;
        w_zcnt_n  = w_free ? r_zcnt - ZW'(1) : r_zcnt;
      end else begin
        w_ld_run  = r_h_run;
        w_ld_size = r_h_size;
        w_ld_amp  = r_h_amp;
        w_state_n = w_free ? S_IDLE : S_FLUSH;
      end
    end else if (w_acc) begin
      if (w_zrl) begin
        w_ld     = (r_zcnt == ZMAX);
        w_zcnt_n = (r_zcnt < ZMAX) ? r_zcnt + ZW'(1) : r_zcnt;
      end else if (w_eob) begin
        w_ld     = 1'b1;
        w_zcnt_n = '0;
        w_drop_n = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      end else if (r_zcnt == '0) begin
        w_ld = 1'b1;
      end else begin
        w_ld      = 1'b1;
        w_ld_run  = 4'd15;
        w_ld_size = '0;
        w_ld_amp  = '0;
        w_zcnt_n  = r_zcnt - ZW'(1);
        w_hold_en = 1'b1;
        w_state_n = S_FLUSH;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_run    <= '0;
      r_size   <= '0;
      r_amp    <= '0;
      r_h_run  <= '0;
      r_h_size <= '0;
      r_h_amp  <= '0;
      r_zcnt   <= '0;
      r_drop   <= '0;
    end else begin
      if (w_ld) begin
        r_valid <= 1'b1;
        r_run   <= w_ld_run;
        r_size  <= w_ld_size;
        r_amp   <= w_ld_amp;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_hold_en) begin
        r_h_run  <= in_run;
        r_h_size <= in_size;
        r_h_amp  <= in_amp;
      end
      r_zcnt  <= w_zcnt_n;
      r_state <= w_state_n;
      r_drop  <= w_drop_n;
    end
  end
endmodule
